// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with occupancy count, programmable
//            almost-full/almost-empty flags, error pulses and optional FWFT.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_accept;
  logic                  rd_accept;

  // Acceptance uses the registered flags, so a full FIFO never passes a write
  // through even when a read frees a slot in the same cycle.
  always_comb begin
    wr_accept = wr_en & ~full_q;
    rd_accept = rd_en & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d         = (count_d == C_DEPTH);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= C_AF);
    almost_empty_d = (count_d <= C_AE);
    overflow_d     = wr_en & full_q;
    underflow_d    = rd_en & empty_q;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of the next state is preloaded; a write landing on the new head
      // slot (empty FIFO, or popping the last entry) is bypassed from data_in.
      always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = (count_d != '0);
        if (count_d != '0) begin
          if (wr_accept && (wr_ptr_q == rd_ptr_d)) begin
            data_out_d = data_in;
          end else begin
            data_out_d = mem[rd_ptr_d];
          end
        end
      end
    end else begin : g_std
      always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_accept;
        if (rd_accept) begin
          data_out_d = mem[rd_ptr_q];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      data_out_q     <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      data_out_q     <= data_out_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Checks standard and FWFT instances side by side against a queue
//            model of the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [7:0] data_in;

  logic [7:0] s_dout, f_dout;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout_s = 8'h00;
  logic [7:0] exp_dout_f = 8'h00;
  logic       exp_rv_s = 1'b0;
  logic       exp_ovf  = 1'b0;
  logic       exp_udf  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std_count", 32'(s_count), 32'(n));
    chk("std_full", 32'(s_full), 32'(n == 16));
    chk("std_empty", 32'(s_empty), 32'(n == 0));
    chk("std_almost_full", 32'(s_af), 32'(n >= 12));
    chk("std_almost_empty", 32'(s_ae), 32'(n <= 4));
    chk("std_overflow", 32'(s_ovf), 32'(exp_ovf));
    chk("std_underflow", 32'(s_udf), 32'(exp_udf));
    chk("std_rd_valid", 32'(s_rv), 32'(exp_rv_s));
    chk("std_data_out", 32'(s_dout), 32'(exp_dout_s));
    chk("fwft_count", 32'(f_count), 32'(n));
    chk("fwft_full", 32'(f_full), 32'(n == 16));
    chk("fwft_empty", 32'(f_empty), 32'(n == 0));
    chk("fwft_almost_full", 32'(f_af), 32'(n >= 12));
    chk("fwft_almost_empty", 32'(f_ae), 32'(n <= 4));
    chk("fwft_overflow", 32'(f_ovf), 32'(exp_ovf));
    chk("fwft_underflow", 32'(f_udf), 32'(exp_udf));
    chk("fwft_rd_valid", 32'(f_rv), 32'(n != 0));
    chk("fwft_data_out", 32'(f_dout), 32'(exp_dout_f));
  endtask

  // One clock: drive, let the edge happen, advance the model, then compare.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rs);
    int n;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      exp_dout_s = 8'h00;
      exp_dout_f = 8'h00;
      exp_rv_s   = 1'b0;
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
    end else begin
      n        = q.size();
      exp_ovf  = w && (n == 16);
      exp_udf  = r && (n == 0);
      exp_rv_s = r && (n != 0);
      if (exp_rv_s) exp_dout_s = q.pop_front();
      if (w && (n != 16)) q.push_back(d);
      if (q.size() != 0) exp_dout_f = q[0];
    end
    #1;
    check_all();
  endtask

  initial begin
    bit w, r, rs;
    int pw;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;

    // Reset state with a write and read presented alongside reset
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0..15, then an overflowing write
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(s_full), 32'd1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_pulse", 32'(s_ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Drain, then an underflowing read
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_last", 32'(s_dout), 32'h0F);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_hold", 32'(s_dout), 32'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Pointer wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last", 32'(s_dout), 32'h2F);

    // Simultaneous read/write at count 8
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    chk("rw_mid_count", 32'(s_count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);

    // Simultaneous at full: 16 -> 15 with overflow
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("rw_full_count", 32'(s_count), 32'd15);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous at empty: 0 -> 1 with underflow, then read 0xFF
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("rw_empty_fwft", 32'(f_dout), 32'hFF);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rw_empty_read", 32'(s_dout), 32'hFF);

    // Mid-operation reset alongside a write, then a read underflows
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT single entry: visible without rd_en, then popped
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("fwft_show", 32'(f_dout), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_rv", 32'(f_rv), 32'd0);

    // Randomised traffic, biased to visit both full and empty
    for (int i = 0; i < 600; i++) begin
      pw = (i < 200) ? 75 : (i < 400) ? 25 : 50;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < (100 - pw));
      rs = ($urandom_range(0, 199) == 0);
      step(w, 8'($urandom), r, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
